// File: rtl/frame_commit_sequencer.sv
// frame_commit_sequencer
// Copies a completed frame from the next-target framebuffer into the target
// framebuffer. The copy starts on a driver frame boundary (i_sync) and only
// while the animator is idle. It is one burst of c_channels words, and the
// frame's time/type header is latched at the start of the burst.
//
// Ports:
//   i_clk, i_rst_n   clock, synchronous active-low reset
//   i_frame_done     pulse: next-target buffer holds a complete frame
//   i_sync           driver latch pulse (frame boundary)
//   i_anim_busy      animator is reading the target buffer
//   o_raddr/i_rdata  next-target read port (1-cycle read latency)
//   i_time/i_type    next-target frame header
//   o_wen/o_waddr/o_wdata  target write port
//   o_time/o_type    committed header, held between commits
//   o_busy           high during COPY and FLUSH
//   o_commit         pulse when the copy is complete
//   o_drop_cnt       (FRAME_COMMIT_DROP_CNT_EN only) frames overwritten before commit
//
// Optional feature macro: FRAME_COMMIT_DROP_CNT_EN
module frame_commit_sequencer #(
  parameter int unsigned c_ledboards = 30,
  parameter int unsigned c_bpc       = 12,
  parameter int unsigned c_max_time  = 1024,
  parameter int unsigned c_max_type  = 64,
  localparam int unsigned c_channels = c_ledboards * 32,
  localparam int unsigned c_addr_w   = $clog2(c_channels),
  localparam int unsigned c_time_w   = $clog2(c_max_time),
  localparam int unsigned c_type_w   = $clog2(c_max_type)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_frame_done,
  input  logic                i_sync,
  input  logic                i_anim_busy,
  output logic [c_addr_w-1:0] o_raddr,
  input  logic [c_bpc-1:0]    i_rdata,
  input  logic [c_time_w-1:0] i_time,
  input  logic [c_type_w-1:0] i_type,
  output logic                o_wen,
  output logic [c_addr_w-1:0] o_waddr,
  output logic [c_bpc-1:0]    o_wdata,
  output logic [c_time_w-1:0] o_time,
  output logic [c_type_w-1:0] o_type,
  output logic                o_busy,
  output logic                o_commit
`ifdef FRAME_COMMIT_DROP_CNT_EN
  ,
  output logic [7:0]          o_drop_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StWait, StCopy, StFlush} state_e;

  // Terminal read address; compared exactly so a non-power-of-two count never wraps.
  localparam logic [c_addr_w-1:0] c_last = c_addr_w'(c_channels - 1);

  state_e                state_q, state_d;
  logic                  pending_q, pending_d;
  logic [c_addr_w-1:0]   raddr_q, raddr_d;
  logic                  wen_q;
  logic [c_addr_w-1:0]   waddr_q;
  logic [c_time_w-1:0]   time_q;
  logic [c_type_w-1:0]   type_q;
  logic                  commit_q;
  logic                  start;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | i_frame_done;
    raddr_d   = '0;
    start     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_frame_done) state_d = StWait;
      end
      StWait: begin
        if (i_sync && !i_anim_busy) begin
          state_d   = StCopy;
          start     = 1'b1;
          // A frame finishing in the very cycle the copy starts stays pending.
          pending_d = i_frame_done;
        end
      end
      StCopy: begin
        if (raddr_q == c_last) state_d = StFlush;
        else                   raddr_d = raddr_q + 1'b1;
      end
      StFlush: begin
        state_d = pending_d ? StWait : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      pending_q <= 1'b0;
      raddr_q   <= '0;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      time_q    <= '0;
      type_q    <= '0;
      commit_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      raddr_q   <= raddr_d;
      // Write side trails the read side by the 1-cycle read latency.
      wen_q     <= (state_q == StCopy);
      if (state_q == StCopy) waddr_q <= raddr_q;
      commit_q  <= (state_q == StFlush);
      if (start) begin
        time_q <= i_time;
        type_q <= i_type;
      end
    end
  end

`ifdef FRAME_COMMIT_DROP_CNT_EN
  logic [7:0] drop_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      drop_q <= '0;
    end else if (i_frame_done && pending_q && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign o_drop_cnt = drop_q;
`endif

  assign o_raddr  = raddr_q;
  assign o_wen    = wen_q;
  assign o_waddr  = waddr_q;
  assign o_wdata  = i_rdata;
  assign o_time   = time_q;
  assign o_type   = type_q;
  assign o_busy   = (state_q == StCopy) || (state_q == StFlush);
  assign o_commit = commit_q;

endmodule

// File: tb/tb_frame_commit_sequencer.sv
// Self-checking bench for frame_commit_sequencer. A burst is modelled as a
// time offset j from COPY entry (cycle T+1+j); every output is derived from j
// and a few flags, and compared every cycle. A directed table, hand-written
// corner sequences and a random phase drive the inputs.
module tb_frame_commit_sequencer;

  localparam int CH = 960;

  logic        clk = 1'b0;
  logic        rst_n, frame_done, sync, anim_busy;
  logic [9:0]  raddr, waddr, tin, tout;
  logic [11:0] rdata, wdata;
  logic [5:0]  yin, yout;
  logic        wen, busy, commit;
`ifdef FRAME_COMMIT_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  always #5 clk = ~clk;

  frame_commit_sequencer dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_frame_done (frame_done),
    .i_sync       (sync),
    .i_anim_busy  (anim_busy),
    .o_raddr      (raddr),
    .i_rdata      (rdata),
    .i_time       (tin),
    .i_type       (yin),
    .o_wen        (wen),
    .o_waddr      (waddr),
    .o_wdata      (wdata),
    .o_time       (tout),
    .o_type       (yout),
    .o_busy       (busy),
    .o_commit     (commit)
`ifdef FRAME_COMMIT_DROP_CNT_EN
    ,
    .o_drop_cnt   (drop_cnt)
`endif
  );

  // Next-target buffer (1-cycle read latency) and target buffer.
  logic [11:0] nt_mem  [CH];
  logic [11:0] tgt_mem [CH];

  always @(posedge clk) begin
    rdata <= nt_mem[raddr];
    if (wen) tgt_mem[waddr] <= wdata;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state.
  int         j = -1;     // offset since COPY entry, -1 when no burst in view
  bit         m_wait, m_pend;
  logic [9:0] m_time, m_waddr;
  logic [5:0] m_type;
  int         m_drop;

  task automatic model_edge();
    bit fd, started;
    fd      = frame_done;
    started = 1'b0;
    if (!rst_n) begin
      j = -1; m_wait = 0; m_pend = 0; m_time = 0; m_type = 0; m_waddr = 0; m_drop = 0;
      return;
    end
    if (fd && m_pend && m_drop < 255) m_drop++;
    if (j >= 0 && j <= 960) begin
      j++;
      if (j == 961) m_wait = m_pend | fd;
    end else begin
      if (j >= 961) j = -1;
      if (m_wait) begin
        if (sync && !anim_busy) begin
          started = 1'b1; j = 0; m_wait = 0; m_time = tin; m_type = yin;
        end
      end else if (fd) begin
        m_wait = 1'b1;
      end
    end
    m_pend = started ? fd : (m_pend | fd);
    if (j >= 1 && j <= 960) m_waddr = 10'(j - 1);
  endtask

  task automatic check_cycle();
    bit ew;
    ew = (j >= 1 && j <= 960);
    check("raddr", raddr, (j >= 0 && j <= 959) ? 64'(j) : 64'd0);
    check("wen", wen, ew);
    check("waddr", waddr, m_waddr);
    check("busy", busy, (j >= 0 && j <= 960));
    check("commit", commit, (j == 961));
    check("time", tout, m_time);
    check("type", yout, m_type);
    if (ew) check("wdata", wdata, nt_mem[j-1]);
`ifdef FRAME_COMMIT_DROP_CNT_EN
    check("drop_cnt", drop_cnt, m_drop);
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_cycle();
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic pulse_fd();
    frame_done = 1'b1; cyc(); frame_done = 1'b0;
  endtask

  task automatic pulse_sync(input bit ab);
    sync = 1'b1; anim_busy = ab; cyc(); sync = 1'b0; anim_busy = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cyc(); cyc(); rst_n = 1'b1;
  endtask

  typedef struct {
    bit rst_n, fd, sync, ab;
    bit exp_busy, exp_wen, exp_commit;
    int exp_raddr;
  } vec_t;

  vec_t vt [13];

  initial begin
    int bad, nw;
    // rst fd sync ab | busy wen commit raddr  (expected after the edge)
    vt[0]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    vt[1]  = '{1, 0, 0, 0, 0, 0, 0, 0};
    vt[2]  = '{1, 0, 1, 0, 0, 0, 0, 0};  // sync in IDLE ignored
    vt[3]  = '{1, 1, 1, 0, 0, 0, 0, 0};  // same-cycle sync not consumed
    vt[4]  = '{1, 0, 0, 0, 0, 0, 0, 0};
    vt[5]  = '{1, 0, 1, 1, 0, 0, 0, 0};  // animator busy: ignored
    vt[6]  = '{1, 0, 0, 0, 0, 0, 0, 0};
    vt[7]  = '{1, 0, 1, 0, 1, 0, 0, 0};  // copy starts
    vt[8]  = '{1, 0, 0, 0, 1, 1, 0, 1};
    vt[9]  = '{1, 1, 0, 0, 1, 1, 0, 2};
    vt[10] = '{0, 0, 0, 0, 0, 0, 0, 0};  // reset aborts burst
    vt[11] = '{1, 0, 1, 0, 0, 0, 0, 0};  // pending was cleared
    vt[12] = '{1, 0, 0, 0, 0, 0, 0, 0};

    for (int i = 0; i < CH; i++) begin
      nt_mem[i]  = 12'(i) ^ 12'hA5A;
      tgt_mem[i] = '0;
    end
    rst_n = 1'b0; frame_done = 1'b0; sync = 1'b0; anim_busy = 1'b0;
    tin = 10'd300; yin = 6'd5;

    for (int i = 0; i < 13; i++) begin
      rst_n = vt[i].rst_n; frame_done = vt[i].fd; sync = vt[i].sync; anim_busy = vt[i].ab;
      cyc();
      check($sformatf("vec%0d_busy", i), busy, vt[i].exp_busy);
      check($sformatf("vec%0d_wen", i), wen, vt[i].exp_wen);
      check($sformatf("vec%0d_commit", i), commit, vt[i].exp_commit);
      check($sformatf("vec%0d_raddr", i), raddr, vt[i].exp_raddr);
    end
    rst_n = 1'b1; frame_done = 1'b0; sync = 1'b0; anim_busy = 1'b0;

    // Full commit of a known pattern and header.
    do_reset();
    for (int i = 0; i < CH; i++) tgt_mem[i] = '0;
    run(4);
    pulse_fd();
    run(14);
    pulse_sync(1'b0);
    run(966);
    bad = 0;
    for (int i = 0; i < CH; i++) if (tgt_mem[i] !== (12'(i) ^ 12'hA5A)) bad++;
    check("pattern_bad_words", bad, 0);
    check("held_time", tout, 10'd300);
    check("held_type", yout, 6'd5);
    tin = 10'd7; yin = 6'd1;
    run(10);
    check("time_unchanged", tout, 10'd300);
    check("idle_after_commit", busy, 1'b0);

    // Sync while animator busy, then a real sync; frame_done mid-copy.
    pulse_fd();
    run(5);
    pulse_sync(1'b1);
    run(20);
    check("no_copy_when_anim_busy", busy, 1'b0);
    pulse_sync(1'b0);
    check("copy_after_sync", busy, 1'b1);
    run(499);
    pulse_fd();
    run(470);
`ifdef FRAME_COMMIT_DROP_CNT_EN
    check("drop_zero_midcopy", drop_cnt, 8'd0);
`endif
    pulse_sync(1'b0);
    nw = 0;
    for (int i = 0; i < 975; i++) begin
      cyc();
      if (wen === 1'b1) nw++;
    end
    check("second_burst_writes", nw, CH);

    // Drop counter.
    do_reset();
    repeat (3) begin pulse_fd(); run(2); end
`ifdef FRAME_COMMIT_DROP_CNT_EN
    check("drop_three", drop_cnt, 8'd2);
`endif
    repeat (300) pulse_fd();
`ifdef FRAME_COMMIT_DROP_CNT_EN
    check("drop_saturate", drop_cnt, 8'd255);
`endif

    // Reset at write 400 of a burst.
    do_reset();
    pulse_fd();
    pulse_sync(1'b0);
    run(401);
    check("at_write_400", waddr, 10'd400);
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    check("rst_wen", wen, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_raddr", raddr, 10'd0);
    pulse_sync(1'b0);
    run(10);
    check("no_copy_after_rst", busy, 1'b0);

    // Random stimulus against the model.
    for (int i = 0; i < 30000; i++) begin
      frame_done = ($urandom_range(0, 59) == 0);
      sync       = ($urandom_range(0, 39) == 0);
      anim_busy  = ($urandom_range(0, 2) == 0);
      rst_n      = ($urandom_range(0, 7999) != 0);
      tin        = 10'($urandom);
      yin        = 6'($urandom);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_commit_sequencer.md
Name: frame_commit_sequencer

Overview:
Sequences the copy of a fully received frame from the next-target framebuffer into the target framebuffer used by the animator. Accepts a frame-complete pulse from the protocol side. Waits for a driver frame boundary (latch pulse) while the animator is idle, then streams all c_channels words plus the frame's time/type header across in one burst. Sits between next_target_frame (read side) and target_frame (write side), in the w_clk domain.

Parameters:
c_ledboards, 30, number of LED boards; c_channels = c_ledboards*32 = 960
c_bpc, 12, bits per channel word
c_max_time, 1024, max transition time; c_time_w = $clog2(c_max_time) = 10
c_max_type, 64, number of transition types; c_type_w = $clog2(c_max_type) = 6

Ports:
i_clk  in  1  block clock (w_clk domain)
i_rst_n  in  1  synchronous reset, active-low
i_frame_done  in  1  1-cycle pulse: next-target buffer holds a complete frame
i_sync  in  1  driver latch pulse (frame boundary)
i_anim_busy  in  1  animator is reading the target buffer; a commit must not start
o_raddr  out  c_addr_w  read address into the next-target buffer
i_rdata  in  c_bpc  next-target read data, valid 1 cycle after o_raddr
i_time  in  c_time_w  next-target frame time header
i_type  in  c_type_w  next-target frame type header
o_wen  out  1  write enable to the target buffer
o_waddr  out  c_addr_w  target write address
o_wdata  out  c_bpc  target write data (= i_rdata, combinational pass-through)
o_time  out  c_time_w  committed time header, held
o_type  out  c_type_w  committed type header, held
o_busy  out  1  high while in COPY or FLUSH
o_commit  out  1  1-cycle pulse when the copy is complete

Behaviour:
- Reset (i_rst_n=0 at a clk edge): state IDLE, pending=0. o_raddr=0, o_wen=0, o_waddr=0, o_time=0, o_type=0, o_busy=0, o_commit=0. Applies mid-copy: the burst aborts immediately and no further writes occur.
- States: IDLE, WAIT, COPY, FLUSH.
- IDLE: on i_frame_done, set pending and go to WAIT.
- WAIT: when i_sync=1 and i_anim_busy=0 in cycle T, go to COPY at T+1 and clear pending. A sync seen while i_anim_busy=1 is ignored; the block waits for the next sync.
- COPY: o_raddr = k in cycle T+1+k, k = 0..c_channels-1. o_time/o_type capture i_time/i_type at T+1. After k = c_channels-1, go to FLUSH.
- Writes: o_wen=1 and o_waddr=k in cycle T+2+k. o_wen is high for exactly c_channels consecutive cycles (T+2..T+961 at default). FLUSH covers the final write.
- FLUSH: o_commit=1 for 1 cycle at T+962. Go to WAIT if pending=1, else IDLE.
- o_raddr returns to 0 outside COPY. o_waddr holds its last value while o_wen=0.
- o_busy=1 for every cycle in COPY or FLUSH.
- i_frame_done during WAIT, COPY or FLUSH sets pending; it never restarts or extends a burst in progress.
- i_frame_done and i_sync in the same IDLE cycle: pending is set, but that sync is not consumed. The commit needs a later sync.
- Address counter widths are c_addr_w. The counter never wraps: the terminal compare is against c_channels-1, not 2^c_addr_w-1.
- o_time/o_type change only at COPY entry.

Optional Feature:
FRAME_COMMIT_DROP_CNT_EN
- Defined: adds output o_drop_cnt [7:0], reset to 0. It increments, saturating at 255, when i_frame_done arrives while pending=1, i.e. a received frame is overwritten before it was committed.
- Undefined: no port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset, frame_done at cycle 5, sync at 20 with anim_busy=0 -> o_raddr 0..959 from cycle 21, o_wen at 22..981 with o_waddr=raddr-1, o_commit at 982, then IDLE.
- Preload next buffer with data=addr^0xA5A, i_time=300, i_type=5 -> target holds the pattern at all 960 addresses; o_time=300, o_type=5 held after commit.
- Sync while anim_busy=1 -> no o_raddr/o_wen activity; the next sync with anim_busy=0 starts the copy 1 cycle later.
- frame_done at cycle 500 of a COPY -> o_commit, then WAIT; the next sync starts a second 960-write burst; with FRAME_COMMIT_DROP_CNT_EN, o_drop_cnt stays 0.
- Three frame_done pulses with no sync -> o_drop_cnt=2 (macro on); 300 pulses -> saturates at 255.
- i_rst_n low at write 400 of a burst -> o_wen=0, o_busy=0, o_raddr=0 the next cycle; pending cleared; a later sync with no frame_done produces no copy.
